imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 28 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and
// the machine's PC reset word address.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // PC reset value [31:2]; the loader's first word lands here.
    localparam logic [29:0] PC_RESET_WORD = 30'h100000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words: first byte ends up in [31:24].
// o_full flags the shift that completes a word, so the caller can act on it the same edge.
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_clear,
    input  logic        i_shift_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift_en) begin
            r_word <= {r_word[23:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_full = i_shift_en & (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: reads a 16-bit word-count header and that many big-endian
// words from a byte stream, writes them from BASE_ADDR up, then releases the machine.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = PC_RESET_WORD,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [29:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t           r_state;
    logic [7:0]       r_len_hi;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_word_idx;
    logic             r_in_ready;
    logic             r_wr_en;
    logic [29:0]      r_wr_addr;
    logic [31:0]      r_wr_data_hold;
    logic             r_cpu_reset;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_accept;
    logic             w_shift_en;
    logic             w_pack_clear;
    logic [31:0]      w_word;
    logic             w_full;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_idx_next;

    assign w_accept     = in_valid & r_in_ready;
    assign w_shift_en   = w_accept & (r_state == ST_DATA);
    assign w_pack_clear = reset | (r_state == ST_LEN_LO);
    assign w_len        = CNT_W'({r_len_hi, in_data});
    assign w_idx_next   = r_word_idx + 1'b1;

    imem_loader_byte_packer u_packer (
        .i_clk      (clk),
        .i_clear    (w_pack_clear),
        .i_shift_en (w_shift_en),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_full     (w_full)
    );

    // Outputs are registered alongside each transition so they match the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_len_hi       <= '0;
            r_count        <= '0;
            r_word_idx     <= '0;
            r_in_ready     <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= BASE_ADDR;
            r_wr_data_hold <= '0;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state     <= ST_LEN_HI;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= in_data;
                        r_state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_count    <= w_len;
                        r_word_idx <= '0;
                        if (w_len == '0) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else if (w_len > CNT_W'(MAX_WORDS)) begin
                            r_state    <= ST_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_full) begin
                        r_state    <= ST_WRITE;
                        r_in_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= BASE_ADDR + 30'(r_word_idx);
                    end
                end
                ST_WRITE: begin
                    r_wr_data_hold <= w_word;
                    r_word_idx     <= w_idx_next;
                    if (w_idx_next == r_count) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state    <= ST_DATA;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The packer holds the complete word throughout WRITE; the hold register keeps it afterwards.
    assign wr_data   = (r_state == ST_WRITE) ? w_word : r_wr_data_hold;
    assign in_ready  = r_in_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
